// File: rtl/sobel_edge_writeback_if.sv
// sobel_edge_writeback_if: gradient stream in (g_valid/g/g_ready) and single-word write bus out (busy/start_write/addr_w/data_w/write_done)
interface sobel_edge_writeback_if;
  logic g_valid;
  logic [10:0] g;
  logic g_ready;
  logic busy;
  logic start_write;
  logic [31:0] addr_w;
  logic [31:0] data_w;
  logic write_done;
  modport master (input g_valid, g, busy, write_done, output g_ready, start_write, addr_w, data_w);
  modport slave (output g_valid, g, busy, write_done, input g_ready, start_write, addr_w, data_w);
endinterface

// File: rtl/sobel_edge_writeback.sv
// sobel_edge_writeback: clamp/threshold gradients, pack 4 px per word, write one frame (ports: clk, rst, start, threshold, bus, active, frame_done)
module sobel_edge_writeback #(
  parameter int OUT_W = 638,
  parameter int OUT_H = 478,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit THRESH_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [7:0] threshold,
  sobel_edge_writeback_if.master bus,
  output logic active,
  output logic frame_done
);
  localparam int N = OUT_W * OUT_H;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, COLLECT, REQ, WAIT_DONE, FINISH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [7:0] thr, c, pix;
  logic take;
  assign c = bus.g > 11'd255 ? 8'hFF : bus.g[7:0];
  assign pix = THRESH_EN ? (c >= thr ? 8'hFF : 8'h00) : c;
  assign take = state == COLLECT && bus.g_valid;
  assign bus.g_ready = state == COLLECT;
  assign bus.start_write = state == REQ && !bus.busy;
  assign active = state inside {COLLECT, REQ, WAIT_DONE};
  assign frame_done = state == FINISH;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? COLLECT : IDLE;
      COLLECT: state_n = take && (idx == 2'd3 || cnt == CW'(N - 1)) ? REQ : COLLECT;
      REQ: state_n = bus.busy ? REQ : WAIT_DONE;
      WAIT_DONE: state_n = !bus.write_done ? WAIT_DONE : cnt < CW'(N) ? COLLECT : FINISH;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      thr <= '0;
      bus.addr_w <= BASE_ADDR;
      bus.data_w <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        thr <= threshold;
        bus.addr_w <= BASE_ADDR;
        bus.data_w <= '0;
        cnt <= '0;
        idx <= '0;
      end
      if (take) begin
        bus.data_w[{idx, 3'b000} +: 8] <= pix;
        idx <= idx + 2'd1;
        cnt <= cnt + 1'b1;
      end
      if (state == WAIT_DONE && bus.write_done) begin
        bus.addr_w <= bus.addr_w + 32'd4;
        bus.data_w <= '0;
        idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_edge_writeback.sv
// tb_sobel_edge_writeback: directed checks of packing, clamping, thresholding, backpressure, abort and random valid
module tb_sobel_edge_writeback;
  localparam logic [31:0] BASE [3] = '{32'h0000_1000, 32'h0000_0000, 32'h0000_2000};
  logic clk = 0;
  logic rst = 1;
  logic start [3];
  logic [7:0] threshold [3];
  logic g_valid [3];
  logic [10:0] g [3];
  logic busy [3];
  logic spur [3];
  logic wd_resp [3];
  logic gr [3];
  logic sw [3];
  logic [31:0] aw [3];
  logic [31:0] dw [3];
  logic act [3];
  logic fdo [3];
  logic [31:0] wa [3][64];
  logic [31:0] wd [3][64];
  logic [31:0] hold_a [3];
  logic [31:0] hold_d [3];
  logic waiting [3];
  int nw [3];
  int nfd [3];
  int rcnt [3];
  int unstable [3];
  int wd_cyc [3];
  int fd_cyc [3];
  logic fd_act [3];
  int cyc = 0;
  int pix [8];
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  sobel_edge_writeback_if bi [3] ();
  for (genvar j = 0; j < 3; j++) begin : g_conn
    assign bi[j].g_valid = g_valid[j];
    assign bi[j].g = g[j];
    assign bi[j].busy = busy[j];
    assign bi[j].write_done = wd_resp[j] | spur[j];
    assign gr[j] = bi[j].g_ready;
    assign sw[j] = bi[j].start_write;
    assign aw[j] = bi[j].addr_w;
    assign dw[j] = bi[j].data_w;
  end
  sobel_edge_writeback #(.OUT_W(4), .OUT_H(2), .BASE_ADDR(32'h0000_1000), .THRESH_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .threshold(threshold[0]), .bus(bi[0]), .active(act[0]), .frame_done(fdo[0]));
  sobel_edge_writeback #(.OUT_W(4), .OUT_H(1), .BASE_ADDR(32'h0000_0000), .THRESH_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .threshold(threshold[1]), .bus(bi[1]), .active(act[1]), .frame_done(fdo[1]));
  sobel_edge_writeback #(.OUT_W(3), .OUT_H(2), .BASE_ADDR(32'h0000_2000), .THRESH_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .threshold(threshold[2]), .bus(bi[2]), .active(act[2]), .frame_done(fdo[2]));
  initial for (int k = 0; k < 3; k++) begin
    nw[k] = 0; nfd[k] = 0; rcnt[k] = 0; unstable[k] = 0; waiting[k] = 0;
    wd_resp[k] = 0; wd_cyc[k] = 0; fd_cyc[k] = 0; fd_act[k] = 0;
  end
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        waiting[k] = 0;
        rcnt[k] = 0;
      end
      if (waiting[k] && (aw[k] !== hold_a[k] || dw[k] !== hold_d[k])) unstable[k]++;
      wd_resp[k] = 0;
      if (rcnt[k] > 0) begin
        rcnt[k]--;
        if (rcnt[k] == 0) begin
          wd_resp[k] = 1;
          waiting[k] = 0;
          wd_cyc[k] = cyc;
        end
      end
      if (sw[k] === 1'b1) begin
        if (nw[k] < 64) begin
          wa[k][nw[k]] = aw[k];
          wd[k][nw[k]] = dw[k];
        end
        nw[k]++;
        hold_a[k] = aw[k];
        hold_d[k] = dw[k];
        waiting[k] = 1;
        rcnt[k] = 2;
      end
      if (fdo[k] === 1'b1) begin
        nfd[k]++;
        fd_cyc[k] = cyc;
        fd_act[k] = act[k];
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start(int k, int thr);
    @(negedge clk);
    start[k] = 1;
    threshold[k] = thr[7:0];
    @(negedge clk);
    start[k] = 0;
  endtask
  task automatic feed(int k, int lo, int hi, bit rnd);
    int i = lo;
    int t = 0;
    while (i <= hi && t < 2000) begin
      @(negedge clk);
      t++;
      g[k] = 11'(pix[i]);
      g_valid[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (g_valid[k] && gr[k]) i++;
    end
    @(negedge clk);
    g_valid[k] = 0;
    checks++;
    if (i <= hi) begin
      errs++;
      $display("FAIL feed%0d: accepted %0d of %0d pixels", k, i - lo, hi - lo + 1);
    end
  endtask
  task automatic wait_frame(int k, int f);
    int t = 0;
    while (nfd[k] == f && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (nfd[k] !== f + 1) begin
      errs++;
      $display("FAIL frame_done%0d: pulses=%0d want %0d", k, nfd[k] - f, 1);
    end
    tick(2);
  endtask
  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({gr[k], sw[k], act[k], fdo[k]} !== 4'b0000 || aw[k] !== BASE[k] || dw[k] !== 32'h0) begin
        errs++;
        $display("FAIL reset%0d: rdy/sw/act/fd=%b%b%b%b addr=%h data=%h want 0000 %h 00000000",
                 k, gr[k], sw[k], act[k], fdo[k], aw[k], dw[k], BASE[k]);
      end
    end
  endtask
  task automatic test_basic;
    int b = nw[0];
    int f = nfd[0];
    logic [31:0] exp [2] = '{32'h04030201, 32'h08070605};
    pix = '{1, 2, 3, 4, 5, 6, 7, 8};
    pulse_start(0, 0);
    checks++;
    if (act[0] !== 1'b1 || gr[0] !== 1'b1) begin
      errs++;
      $display("FAIL basic_collect: active=%b g_ready=%b want 1 1", act[0], gr[0]);
    end
    feed(0, 0, 7, 0);
    checks++;
    if (gr[0] !== 1'b0) begin
      errs++;
      $display("FAIL basic_ready_drop: g_ready=%b want 0", gr[0]);
    end
    wait_frame(0, f);
    checks++;
    if (nw[0] - b !== 2) begin
      errs++;
      $display("FAIL basic_count: writes=%0d want 2", nw[0] - b);
    end
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (wa[0][b+w] !== 32'h1000 + 32'(4 * w) || wd[0][b+w] !== exp[w]) begin
        errs++;
        $display("FAIL basic_word%0d: addr=%h data=%h want %h %h", w, wa[0][b+w], wd[0][b+w], 32'h1000 + 32'(4 * w), exp[w]);
      end
    end
    checks++;
    if (fd_cyc[0] - wd_cyc[0] !== 1 || fd_act[0] !== 1'b0 || unstable[0] !== 0) begin
      errs++;
      $display("FAIL basic_done: done_lag=%0d active=%b unstable=%0d want 1 0 0", fd_cyc[0] - wd_cyc[0], fd_act[0], unstable[0]);
    end
  endtask
  task automatic test_threshold;
    int b = nw[1];
    pix = '{99, 100, 2040, 0, 0, 0, 0, 0};
    pulse_start(1, 100);
    feed(1, 0, 3, 0);
    wait_frame(1, nfd[1]);
    checks++;
    if (nw[1] - b !== 1 || wa[1][b] !== 32'h0 || wd[1][b] !== 32'h00FFFF00) begin
      errs++;
      $display("FAIL thresh100: writes=%0d addr=%h data=%h want 1 00000000 00ffff00", nw[1] - b, wa[1][b], wd[1][b]);
    end
    pix = '{0, 0, 0, 0, 0, 0, 0, 0};
    pulse_start(1, 0);
    feed(1, 0, 3, 0);
    wait_frame(1, nfd[1]);
    checks++;
    if (nw[1] - b !== 2 || wd[1][b+1] !== 32'hFFFFFFFF) begin
      errs++;
      $display("FAIL thresh0: writes=%0d data=%h want 2 ffffffff", nw[1] - b, wd[1][b+1]);
    end
  endtask
  task automatic test_clamp;
    int b = nw[0];
    pix = '{300, 255, 256, 2040, 1, 2, 3, 4};
    pulse_start(0, 200);
    feed(0, 0, 7, 0);
    wait_frame(0, nfd[0]);
    checks++;
    if (nw[0] - b !== 2 || wd[0][b] !== 32'hFFFFFFFF || wd[0][b+1] !== 32'h04030201) begin
      errs++;
      $display("FAIL clamp: writes=%0d data0=%h data1=%h want 2 ffffffff 04030201", nw[0] - b, wd[0][b], wd[0][b+1]);
    end
  endtask
  task automatic test_partial;
    int b = nw[2];
    pix = '{1, 2, 3, 4, 5, 6, 0, 0};
    pulse_start(2, 0);
    feed(2, 0, 5, 0);
    wait_frame(2, nfd[2]);
    checks++;
    if (nw[2] - b !== 2) begin
      errs++;
      $display("FAIL partial_count: writes=%0d want 2", nw[2] - b);
    end
    checks++;
    if (wa[2][b] !== 32'h2000 || wd[2][b] !== 32'h04030201 || wa[2][b+1] !== 32'h2004 || wd[2][b+1] !== 32'h00000605) begin
      errs++;
      $display("FAIL partial_words: %h:%h %h:%h want 00002000:04030201 00002004:00000605", wa[2][b], wd[2][b], wa[2][b+1], wd[2][b+1]);
    end
  endtask
  task automatic test_busy;
    int b = nw[0];
    int bad = 0;
    pix = '{1, 2, 3, 4, 5, 6, 7, 8};
    busy[0] = 1;
    pulse_start(0, 0);
    feed(0, 0, 3, 0);
    repeat (10) begin
      @(negedge clk);
      if (sw[0] !== 1'b0 || gr[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || nw[0] !== b || act[0] !== 1'b1) begin
      errs++;
      $display("FAIL busy_hold: bad_cycles=%0d writes=%0d active=%b want 0 0 1", bad, nw[0] - b, act[0]);
    end
    @(posedge clk);
    #1 busy[0] = 0;
    #1;
    checks++;
    if (sw[0] !== 1'b1 || aw[0] !== 32'h1000 || dw[0] !== 32'h04030201) begin
      errs++;
      $display("FAIL busy_release: start_write=%b addr=%h data=%h want 1 00001000 04030201", sw[0], aw[0], dw[0]);
    end
    feed(0, 4, 7, 0);
    wait_frame(0, nfd[0]);
    checks++;
    if (nw[0] - b !== 2 || wd[0][b+1] !== 32'h08070605 || wa[0][b+1] !== 32'h1004 || unstable[0] !== 0) begin
      errs++;
      $display("FAIL busy_frame: writes=%0d addr=%h data=%h unstable=%0d want 2 00001004 08070605 0", nw[0] - b, wa[0][b+1], wd[0][b+1], unstable[0]);
    end
  endtask
  task automatic test_abort;
    int b = nw[0];
    int f = nfd[0];
    pix = '{1, 2, 3, 4, 5, 6, 7, 8};
    pulse_start(0, 0);
    feed(0, 0, 1, 0);
    @(negedge clk);
    start[0] = 1;
    spur[0] = 1;
    @(negedge clk);
    start[0] = 0;
    spur[0] = 0;
    checks++;
    if (act[0] !== 1'b1 || gr[0] !== 1'b1 || nw[0] !== b || aw[0] !== 32'h1000) begin
      errs++;
      $display("FAIL abort_spurious: active=%b g_ready=%b writes=%0d addr=%h want 1 1 0 00001000", act[0], gr[0], nw[0] - b, aw[0]);
    end
    feed(0, 2, 3, 0);
    tick(1);
    checks++;
    if (nw[0] - b !== 1 || wd[0][b] !== 32'h04030201 || act[0] !== 1'b1) begin
      errs++;
      $display("FAIL abort_word: writes=%0d data=%h active=%b want 1 04030201 1", nw[0] - b, wd[0][b], act[0]);
    end
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    checks++;
    if ({gr[0], sw[0], act[0], fdo[0]} !== 4'b0000 || aw[0] !== 32'h1000 || dw[0] !== 32'h0) begin
      errs++;
      $display("FAIL abort_reset: rdy/sw/act/fd=%b%b%b%b addr=%h data=%h want 0000 00001000 00000000", gr[0], sw[0], act[0], fdo[0], aw[0], dw[0]);
    end
    tick(10);
    checks++;
    if (nfd[0] !== f || nw[0] - b !== 1) begin
      errs++;
      $display("FAIL abort_quiet: frame_done=%0d writes=%0d want 0 1", nfd[0] - f, nw[0] - b);
    end
    pulse_start(0, 0);
    feed(0, 0, 7, 0);
    wait_frame(0, f);
    checks++;
    if (nw[0] - b !== 3 || wa[0][b+1] !== 32'h1000 || wd[0][b+1] !== 32'h04030201 || wa[0][b+2] !== 32'h1004 || wd[0][b+2] !== 32'h08070605) begin
      errs++;
      $display("FAIL abort_restart: writes=%0d %h:%h %h:%h want 3 00001000:04030201 00001004:08070605", nw[0] - b, wa[0][b+1], wd[0][b+1], wa[0][b+2], wd[0][b+2]);
    end
  endtask
  task automatic test_random_valid;
    int b = nw[0];
    pix = '{1, 2, 3, 4, 5, 6, 7, 8};
    pulse_start(0, 0);
    feed(0, 0, 7, 1);
    wait_frame(0, nfd[0]);
    checks++;
    if (nw[0] - b !== 2 || wd[0][b] !== 32'h04030201 || wd[0][b+1] !== 32'h08070605 || wa[0][b+1] !== 32'h1004) begin
      errs++;
      $display("FAIL random_valid: writes=%0d data0=%h data1=%h addr1=%h want 2 04030201 08070605 00001004", nw[0] - b, wd[0][b], wd[0][b+1], wa[0][b+1]);
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      start[k] = 0; threshold[k] = 0; g_valid[k] = 0; g[k] = 0; busy[k] = 0; spur[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    test_reset;
    test_basic;
    test_threshold;
    test_clamp;
    test_partial;
    test_busy;
    test_abort;
    test_random_valid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sobel_edge_writeback.md
Name: sobel_edge_writeback

Overview:
Downstream stage of the total-gradient unit in the Sobel edge-detection datapath. Consumes one gradient magnitude per handshake and clamps it to 8 bits. Optionally thresholds each value to a binary edge map, then packs four pixels per 32-bit word. Issues single-word write requests to the memory read/write controller until one output frame is stored, then pulses frame_done.

Parameters:
OUT_W, 638, output image width in pixels (input width minus 2)
OUT_H, 478, output image height in pixels
BASE_ADDR, 32'h0000_0000, byte address of the first output word
THRESH_EN, 1, 1 = binary edge output (8'hFF/8'h00); 0 = clamped magnitude output

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; begins a frame and samples threshold
threshold  input  8  edge threshold, sampled on accepted start
g_valid  input  1  gradient sample valid
g  input  11  gradient magnitude |gx|+|gy|, range 0..2040
g_ready  output  1  block accepts g this cycle when g_valid=1
busy  input  1  read/write controller busy
start_write  output  1  one-cycle write request
addr_w  output  32  write byte address
data_w  output  32  write data
write_done  input  1  one-cycle pulse: controller finished the write
active  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the final word completes

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; g_ready=0, start_write=0, addr_w=BASE_ADDR, data_w=0, active=0, frame_done=0. Pixel counter, byte index, and threshold register are cleared.
- Reset mid-frame aborts immediately. No further write is issued, and frame_done is not pulsed.
- Pixel conversion: c = (g > 255) ? 255 : g[7:0]. With THRESH_EN=1, pixel = (c >= thr_reg) ? 8'hFF : 8'h00; otherwise pixel = c. thr_reg=0 therefore maps every pixel to 8'hFF.
- Packing is little-endian: byte index 0 goes to data_w[7:0] and byte index 3 goes to data_w[31:24].
- Pixel total N = OUT_W*OUT_H. Counters are wide enough for N.
- FSM states: IDLE, COLLECT, REQ, WAIT_DONE, FINISH.
- IDLE: g_ready=0, active=0. On start=1, sample threshold, set addr_w=BASE_ADDR, clear data_w, pixel count, and byte index, then go to COLLECT.
- COLLECT: g_ready=1, active=1. On g_valid=1 (same cycle accept), write pixel into byte[idx], increment idx and pixel count.
  - If idx was 3, or this was pixel N, go to REQ next cycle. g_ready drops the cycle after the last accepted pixel.
  - Unfilled bytes of a final partial word remain 0.
- REQ: g_ready=0. When busy=0, assert start_write for exactly one cycle and go to WAIT_DONE. When busy=1, hold without asserting start_write.
- WAIT_DONE: addr_w and data_w are held stable from the start_write cycle until write_done.
  - On write_done=1, addr_w += 4, data_w cleared, idx cleared.
  - Next state is COLLECT if pixel count < N, otherwise FINISH.
- FINISH: frame_done=1 for one cycle, then IDLE. active falls together with frame_done in that cycle.
- Ignored inputs:
  - start outside IDLE is ignored.
  - write_done outside WAIT_DONE is ignored.
  - g_valid while g_ready=0 is not consumed; the upstream source holds g.
- Words written per frame = ceil(N/4). The last address is BASE_ADDR + 4*(ceil(N/4)-1).
- Throughput bound: at most 4 pixels per write round trip. There is no overlap of collection with an outstanding write.

Test Plan:
1. OUT_W=4, OUT_H=2, THRESH_EN=0, start, g = 1,2,3,4,5,6,7,8 back-to-back, busy=0, write_done 2 cycles after each start_write -> writes (BASE,32'h04030201), then (BASE+4,32'h08070605); frame_done one cycle after the second write_done.
2. THRESH_EN=1, threshold=100, g = 99,100,2040,0 -> data_w=32'h00FFFF00. With THRESH_EN=0, g=300,255,256,2040 -> data_w=32'hFFFFFFFF.
3. OUT_W=3, OUT_H=2 (N=6), g = 1..6 -> second word 32'h00000605 at BASE+4; exactly 2 start_write pulses.
4. Hold busy=1 for 10 cycles in REQ -> no start_write and g_ready=0 throughout; start_write fires the first cycle busy=0, and addr/data are stable until write_done.
5. Assert start and a spurious write_done during COLLECT, then rst mid-WAIT_DONE -> no state change from the spurious pulses. After rst all outputs are at reset values and frame_done never pulses; a new start then completes a full frame normally.
6. Toggle g_valid randomly with 50% duty -> packed words are identical to case 1 and no sample is lost or duplicated.
